// File: rtl/spike_decider.sv
// spike_decider: winner-take-all decision over N per-neuron spike counts (with class lookup).
// Latency: a rising edge on deciding that is sampled at edge E gives valid_deciding in the cycle after edge E+N+2.
// Backpressure: none; starts only from IDLE on a deciding 0->1 edge, and edges seen while busy are dropped.
// Ports: clk, rst (sync, active-high), deciding, train_test_classify, spike_cnt_bus, neuron_label ->
//        winner, winner_cnt, class_out, no_spike, busy, valid_deciding
module spike_decider #(
  parameter int N  = 8,
  parameter int CW = 8,
  parameter int LW = 4,
  parameter int IW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            deciding,
  input  logic [1:0]      train_test_classify,
  input  logic [N*CW-1:0] spike_cnt_bus,
  input  logic [N*LW-1:0] neuron_label,
  output logic [IW-1:0]   winner,
  output logic [CW-1:0]   winner_cnt,
  output logic [LW-1:0]   class_out,
  output logic            no_spike,
  output logic            busy,
  output logic            valid_deciding
);

  typedef enum logic [1:0] {S_IDLE, S_SNAP, S_SCAN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic            deciding_d;
  logic            start;
  logic [N*CW-1:0] shadow_cnt;
  logic [N*LW-1:0] shadow_label;
  logic [1:0]      shadow_mode;
  logic [CW-1:0]   best;
  logic [IW-1:0]   best_idx;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   cur_cnt;
  logic [LW-1:0]   best_label;
  logic            last_idx;
  logic            label_mode;

  assign start      = deciding & ~deciding_d;
  assign last_idx   = (idx == IW'(N - 1));
  // Modes 10 (test) and 11 (classify) report a label; 01 and 00 are treated as train.
  assign label_mode = shadow_mode[1];

  // Select the count of the neuron under scan and the label of the current best neuron.
  always_comb begin
    cur_cnt    = '0;
    best_label = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IW'(i))      cur_cnt    = shadow_cnt[i*CW +: CW];
      if (best_idx == IW'(i)) best_label = shadow_label[i*LW +: LW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_SNAP;
      S_SNAP: begin
        busy      = 1'b1;
        state_nxt = S_SCAN;
      end
      S_SCAN: begin
        busy = 1'b1;
        if (last_idx) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deciding_d     <= 1'b0;
      shadow_cnt     <= '0;
      shadow_label   <= '0;
      shadow_mode    <= '0;
      best           <= '0;
      best_idx       <= '0;
      idx            <= '0;
      winner         <= '0;
      winner_cnt     <= '0;
      class_out      <= '0;
      no_spike       <= 1'b0;
      valid_deciding <= 1'b0;
    end else begin
      deciding_d     <= deciding;
      valid_deciding <= 1'b0;
      case (state)
        S_SNAP: begin
          shadow_cnt   <= spike_cnt_bus;
          shadow_label <= neuron_label;
          shadow_mode  <= train_test_classify;
          best         <= '0;
          best_idx     <= '0;
          idx          <= '0;
        end
        S_SCAN: begin
          // Strict compare: on a tie the earlier (lower) index is kept.
          if (cur_cnt > best) begin
            best     <= cur_cnt;
            best_idx <= idx;
          end
          idx <= idx + 1'b1;
        end
        S_DONE: begin
          winner         <= best_idx;
          winner_cnt     <= best;
          no_spike       <= (best == '0);
          valid_deciding <= 1'b1;
          if (!label_mode)      class_out <= '0;
          else if (best == '0)  class_out <= '1;  // all-ones marks an unknown class
          else                  class_out <= best_label;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_decider.sv
// Scoreboard bench for spike_decider: a reference model computes the expected result when a decision is launched,
// and a monitor checks each valid_deciding pulse (values and arrival cycle) against the queue.
module tb_spike_decider;
  localparam int N  = 8;
  localparam int CW = 8;
  localparam int LW = 4;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            deciding;
  logic [1:0]      train_test_classify;
  logic [N*CW-1:0] spike_cnt_bus;
  logic [N*LW-1:0] neuron_label;
  logic [IW-1:0]   winner;
  logic [CW-1:0]   winner_cnt;
  logic [LW-1:0]   class_out;
  logic            no_spike;
  logic            busy;
  logic            valid_deciding;

  typedef struct {
    logic [IW-1:0] win;
    logic [CW-1:0] cnt;
    logic [LW-1:0] cls;
    logic          nsp;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests  = 0;
  int   n_failed = 0;
  int   cyc      = 0;
  int   pulses   = 0;

  spike_decider #(.N(N), .CW(CW), .LW(LW), .IW(IW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .deciding            (deciding),
    .train_test_classify (train_test_classify),
    .spike_cnt_bus       (spike_cnt_bus),
    .neuron_label        (neuron_label),
    .winner              (winner),
    .winner_cnt          (winner_cnt),
    .class_out           (class_out),
    .no_spike            (no_spike),
    .busy                (busy),
    .valid_deciding      (valid_deciding)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (valid_deciding === 1'b1) begin
      exp_t e;
      pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(valid_deciding), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("winner",     32'(winner),     32'(e.win));
        check("winner_cnt", 32'(winner_cnt), 32'(e.cnt));
        check("class_out",  32'(class_out),  32'(e.cls));
        check("no_spike",   32'(no_spike),   32'(e.nsp));
        check("latency",    32'(cyc),        32'(e.cyc));
      end
    end
  end

  // Reference model over the currently driven inputs; raise deciding at a negedge.
  task automatic launch();
    exp_t          e;
    logic [CW-1:0] b;
    logic [IW-1:0] bi;
    logic [CW-1:0] c;
    b  = '0;
    bi = '0;
    for (int i = 0; i < N; i++) begin
      c = spike_cnt_bus[i*CW +: CW];
      if (c > b) begin
        b  = c;
        bi = IW'(i);
      end
    end
    e.win = bi;
    e.cnt = b;
    e.nsp = (b == 0);
    if (train_test_classify == 2'b10 || train_test_classify == 2'b11)
      e.cls = (b == 0) ? 4'hF : neuron_label[bi*LW +: LW];
    else
      e.cls = '0;
    e.cyc = cyc + N + 3;
    exp_q.push_back(e);
    deciding = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check("timeout_pending", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic set_counts(input logic [CW-1:0] c0, c1, c2, c3, c4, c5, c6, c7);
    spike_cnt_bus = {c7, c6, c5, c4, c3, c2, c1, c0};
  endtask

  initial begin
    int p0;
    rst = 1'b1;
    deciding = 1'b0;
    train_test_classify = 2'b01;
    spike_cnt_bus = '0;
    neuron_label = '0;
    repeat (3) @(negedge clk);
    check("rst_winner", 32'(winner), 32'd0);
    check("rst_cnt",    32'(winner_cnt), 32'd0);
    check("rst_class",  32'(class_out), 32'd0);
    check("rst_nsp",    32'(no_spike), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_valid",  32'(valid_deciding), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: train mode, tie between 1 and 3 -> lowest index wins
    for (int i = 0; i < N; i++) neuron_label[i*LW +: LW] = LW'(i + 1);
    set_counts(3, 9, 2, 9, 0, 0, 0, 0);
    train_test_classify = 2'b01;
    launch();
    repeat (3) @(negedge clk);
    check("busy_scan", 32'(busy), 32'd1);
    wait_done(N + 8);
    check("busy_after", 32'(busy), 32'd0);
    deciding = 1'b0;
    @(negedge clk);

    // 2: classify mode, neuron 5 wins with label 6
    set_counts(1, 4, 2, 0, 3, 7, 4, 1);
    neuron_label[5*LW +: LW] = 4'd6;
    train_test_classify = 2'b11;
    launch();
    wait_done(N + 8);
    deciding = 1'b0;
    @(negedge clk);

    // 3: all zero in test mode -> unknown class
    set_counts(0, 0, 0, 0, 0, 0, 0, 0);
    train_test_classify = 2'b10;
    launch();
    wait_done(N + 8);
    check("hold_nsp", 32'(no_spike), 32'd1);

    // 4: deciding held high -> no retrigger; re-raise -> second pulse
    p0 = pulses;
    for (int k = 0; k < 3 * N; k++) begin
      @(negedge clk);
      check("hold_busy", 32'(busy), 32'd0);
    end
    check("hold_pulses", 32'(pulses - p0), 32'd0);
    check("hold_class", 32'(class_out), 32'hF);
    deciding = 1'b0;
    @(negedge clk);
    set_counts(0, 0, 0, 0, 0, 0, 0, 5);
    train_test_classify = 2'b00;
    launch();
    wait_done(N + 8);
    check("retrig_pulses", 32'(pulses - p0), 32'd1);
    deciding = 1'b0;
    @(negedge clk);

    // 5: inputs overwritten after the snapshot have no effect
    set_counts(1, 2, 50, 3, 4, 5, 6, 10);
    neuron_label[2*LW +: LW] = 4'd9;
    train_test_classify = 2'b10;
    launch();
    repeat (4) @(negedge clk);
    spike_cnt_bus[7*CW +: CW] = 8'hFF;
    train_test_classify = 2'b01;
    deciding = 1'b0;  // falling mid-scan is ignored
    wait_done(N + 8);
    @(negedge clk);

    // 6: reset during SCAN at idx 4 aborts with cleared outputs
    set_counts(9, 1, 1, 1, 1, 1, 1, 1);
    train_test_classify = 2'b11;
    p0 = pulses;
    deciding = 1'b1;
    repeat (6) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    deciding = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_winner", 32'(winner), 32'd0);
    check("abort_cnt",    32'(winner_cnt), 32'd0);
    check("abort_class",  32'(class_out), 32'd0);
    check("abort_busy",   32'(busy), 32'd0);
    repeat (N + 4) @(negedge clk);
    check("abort_pulses", 32'(pulses - p0), 32'd0);
    set_counts(3, 9, 2, 9, 0, 0, 0, 0);
    train_test_classify = 2'b01;
    launch();
    wait_done(N + 8);
    deciding = 1'b0;
    @(negedge clk);

    // Random decisions across all modes
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < N; i++) begin
        spike_cnt_bus[i*CW +: CW] = CW'($urandom_range(0, (t % 3 == 0) ? 3 : 255));
        neuron_label[i*LW +: LW]  = LW'($urandom_range(0, 15));
      end
      train_test_classify = 2'($urandom_range(0, 3));
      launch();
      wait_done(N + 8);
      deciding = 1'b0;
      @(negedge clk);
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
